// File: rtl/stack_store_log_scanner_if.sv
// -----------------------------------------------------------------------------
// stack_store_log_scanner_if
//
// Purpose : groups the write, flush, query and response signals of the
//           stack-store log scanner into a single bundle.
//
// Signals :
//   wr_valid_i / wr_addr_i        log write from the branch unit
//   flush_i                       empty the log and abort any scan
//   query_valid_i / query_ready_o lookup request handshake
//   query_addr_i                  address to look up
//   resp_valid_o / resp_ready_i   response handshake
//   resp_hit_o / resp_index_o     lookup result (slot index 0 on a miss)
//   count_o                       number of valid log entries
//
// Modports: master drives requests and writes, slave is the scanner.
// -----------------------------------------------------------------------------
interface stack_store_log_scanner_if #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic          wr_valid_i;
    logic [AW-1:0] wr_addr_i;
    logic          flush_i;
    logic          query_valid_i;
    logic          query_ready_o;
    logic [AW-1:0] query_addr_i;
    logic          resp_valid_o;
    logic          resp_ready_i;
    logic          resp_hit_o;
    logic [IW-1:0] resp_index_o;
    logic [CW-1:0] count_o;

    modport master (
        output wr_valid_i, wr_addr_i, flush_i,
        output query_valid_i, query_addr_i, resp_ready_i,
        input  query_ready_o, resp_valid_o, resp_hit_o, resp_index_o, count_o
    );

    modport slave (
        input  wr_valid_i, wr_addr_i, flush_i,
        input  query_valid_i, query_addr_i, resp_ready_i,
        output query_ready_o, resp_valid_o, resp_hit_o, resp_index_o, count_o
    );
endinterface

// File: rtl/stack_store_log_scanner.sv
// -----------------------------------------------------------------------------
// stack_store_log_scanner
//
// Purpose : circular log of sp/fp-relative store addresses written by the
//           branch unit, with a newest-first multi-cycle lookup scan that the
//           crash/flag logic queries through a valid/ready handshake.
//
// Ports   :
//   clk_i  clock
//   rst_i  asynchronous active-high reset
//   bus    stack_store_log_scanner_if.slave (write, flush, query, response,
//          entry count)
//
// Parameters: DEPTH entries (power of 2, >= 2), AW address bits, MATCH_LSB low
//             address bits ignored when comparing (word granularity).
// -----------------------------------------------------------------------------
module stack_store_log_scanner #(
    parameter int DEPTH     = 8,
    parameter int AW        = 32,
    parameter int MATCH_LSB = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    stack_store_log_scanner_if.slave      bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    logic [AW-1:0] mem [DEPTH];
    logic [IW-1:0] wptr;
    logic [CW-1:0] count;

    state_t        state,     state_n;
    logic [IW-1:0] idx,       idx_n;
    logic [CW-1:0] remain,    remain_n;
    logic [AW-1:0] q_addr,    q_addr_n;
    logic          hit,       hit_n;
    logic [IW-1:0] hit_idx,   hit_idx_n;
    logic          slot_match;

    // Log storage. Contents are don't-care after reset, so no reset here.
    // A flush with a simultaneous write puts the new entry in slot 0.
    always_ff @(posedge clk_i) begin
        if (bus.wr_valid_i) begin
            if (bus.flush_i) begin
                mem[0] <= bus.wr_addr_i;
            end else begin
                mem[wptr] <= bus.wr_addr_i;
            end
        end
    end

    // Write pointer and occupancy. The count saturates at DEPTH; once full,
    // new writes silently overwrite the oldest slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr  <= '0;
            count <= '0;
        end else if (bus.flush_i) begin
            wptr  <= bus.wr_valid_i ? IW'(1) : '0;
            count <= bus.wr_valid_i ? CW'(1) : '0;
        end else if (bus.wr_valid_i) begin
            wptr <= wptr + IW'(1);
            if (count != CW'(DEPTH)) begin
                count <= count + CW'(1);
            end
        end
    end

    // Word-granular compare of the slot under the scan index.
    assign slot_match = (mem[idx][AW-1:MATCH_LSB] == q_addr[AW-1:MATCH_LSB]);

    // Scanner state register and the registered query/result fields.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            idx     <= '0;
            remain  <= '0;
            q_addr  <= '0;
            hit     <= 1'b0;
            hit_idx <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            remain  <= remain_n;
            q_addr  <= q_addr_n;
            hit     <= hit_n;
            hit_idx <= hit_idx_n;
        end
    end

    // Next-state logic. The query snapshots the pre-write count and the
    // newest slot (wptr-1), then walks backwards one slot per cycle; the
    // IW-bit index wraps 0 -> DEPTH-1 on its own since DEPTH is a power of 2.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        remain_n  = remain;
        q_addr_n  = q_addr;
        hit_n     = hit;
        hit_idx_n = hit_idx;
        unique case (state)
            IDLE: begin
                if (bus.query_valid_i) begin
                    q_addr_n  = bus.query_addr_i;
                    idx_n     = wptr - IW'(1);
                    remain_n  = count;
                    hit_n     = 1'b0;
                    hit_idx_n = '0;
                    state_n   = (count == '0) ? RESP : SCAN;
                end
            end
            SCAN: begin
                if (bus.flush_i) begin
                    hit_n     = 1'b0;
                    hit_idx_n = '0;
                    state_n   = RESP;
                end else if (slot_match) begin
                    hit_n     = 1'b1;
                    hit_idx_n = idx;
                    state_n   = RESP;
                end else if (remain == CW'(1)) begin
                    hit_n     = 1'b0;
                    hit_idx_n = '0;
                    state_n   = RESP;
                end else begin
                    idx_n    = idx - IW'(1);
                    remain_n = remain - CW'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.query_ready_o = (state == IDLE);
    assign bus.resp_valid_o  = (state == RESP);
    assign bus.resp_hit_o    = hit;
    assign bus.resp_index_o  = hit_idx;
    assign bus.count_o       = count;

endmodule

// File: tb/tb_stack_store_log_scanner.sv
// -----------------------------------------------------------------------------
// tb_stack_store_log_scanner
//
// Purpose : directed self-checking bench for stack_store_log_scanner with
//           DEPTH=8, AW=32, MATCH_LSB=2.
// -----------------------------------------------------------------------------
module tb_stack_store_log_scanner;
    localparam int DEPTH = 8;
    localparam int AW    = 32;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    stack_store_log_scanner_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

    stack_store_log_scanner #(.DEPTH(DEPTH), .AW(AW), .MATCH_LSB(2)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        exp_hit;
        logic [2:0]  exp_idx;
        int          exp_lat;
    } query_vec_t;

    query_vec_t vecs [4];

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic write_entry(input logic [31:0] addr);
        bus.wr_valid_i = 1'b1;
        bus.wr_addr_i  = addr;
        tick();
        bus.wr_valid_i = 1'b0;
    endtask

    // Issue a query, measure latency from the accept edge, check the result,
    // then complete the response handshake.
    task automatic apply_stimulus(input string name, input logic [31:0] addr,
                                  input logic exp_hit, input logic [2:0] exp_idx,
                                  input int exp_lat);
        int lat;
        check_output({name, " query_ready before"}, 32'(bus.query_ready_o), 32'd1);
        bus.query_valid_i = 1'b1;
        bus.query_addr_i  = addr;
        tick();
        bus.query_valid_i = 1'b0;
        lat = 1;
        while (!bus.resp_valid_o && lat < 50) begin
            tick();
            lat++;
        end
        check_output({name, " resp_valid"}, 32'(bus.resp_valid_o), 32'd1);
        check_output({name, " latency"}, 32'(lat), 32'(exp_lat));
        check_output({name, " hit"}, 32'(bus.resp_hit_o), 32'(exp_hit));
        check_output({name, " index"}, 32'(bus.resp_index_o), 32'(exp_idx));
        bus.resp_ready_i = 1'b1;
        tick();
        bus.resp_ready_i = 1'b0;
        check_output({name, " query_ready after"}, 32'(bus.query_ready_o), 32'd1);
        check_output({name, " resp_valid after"}, 32'(bus.resp_valid_o), 32'd0);
    endtask

    initial begin
        int lat;

        bus.wr_valid_i    = 1'b0;
        bus.wr_addr_i     = '0;
        bus.flush_i       = 1'b0;
        bus.query_valid_i = 1'b0;
        bus.query_addr_i  = '0;
        bus.resp_ready_i  = 1'b0;

        // A0..A9 = 0x9000_0000 + 4*i; after 10 writes slot0=A8, slot1=A9,
        // slots 2..7 = A2..A7, newest order 1,0,7,6,5,4,3,2.
        vecs[0] = '{"A0 evicted",  32'h9000_0000, 1'b0, 3'd0, 9};
        vecs[1] = '{"A9 newest",   32'h9000_0024, 1'b1, 3'd1, 2};
        vecs[2] = '{"A2 oldest",   32'h9000_0008, 1'b1, 3'd2, 9};
        vecs[3] = '{"A5 byte off", 32'h9000_0017, 1'b1, 3'd5, 6};

        // Reset values while reset is held.
        #12;
        check_output("reset query_ready", 32'(bus.query_ready_o), 32'd1);
        check_output("reset resp_valid", 32'(bus.resp_valid_o), 32'd0);
        check_output("reset resp_hit", 32'(bus.resp_hit_o), 32'd0);
        check_output("reset resp_index", 32'(bus.resp_index_o), 32'd0);
        check_output("reset count", 32'(bus.count_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // Empty log: miss one cycle after accept.
        apply_stimulus("empty query", 32'h8000_0010, 1'b0, 3'd0, 1);
        check_output("empty count", 32'(bus.count_o), 32'd0);

        // Three writes, second-newest hit with low bits ignored.
        write_entry(32'h8000_0100);
        write_entry(32'h8000_0104);
        write_entry(32'h8000_0108);
        check_output("count after 3", 32'(bus.count_o), 32'd3);
        apply_stimulus("word match", 32'h8000_0105, 1'b1, 3'd1, 3);

        // Flush, then overfill with 10 entries.
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check_output("count after flush", 32'(bus.count_o), 32'd0);
        for (int i = 0; i < 10; i++) begin
            write_entry(32'h9000_0000 + 32'(4 * i));
        end
        check_output("count saturated", 32'(bus.count_o), 32'd8);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(vecs[i].name, vecs[i].addr, vecs[i].exp_hit,
                           vecs[i].exp_idx, vecs[i].exp_lat);
        end

        // Response held under back-pressure; a query pulse must be ignored.
        bus.query_valid_i = 1'b1;
        bus.query_addr_i  = 32'h9000_0024;
        tick();
        bus.query_valid_i = 1'b0;
        tick();
        check_output("hold resp_valid initial", 32'(bus.resp_valid_o), 32'd1);
        for (int c = 0; c < 5; c++) begin
            bus.query_valid_i = (c == 2);
            bus.query_addr_i  = 32'h9000_0008;
            tick();
            check_output("hold resp_valid", 32'(bus.resp_valid_o), 32'd1);
            check_output("hold resp_hit", 32'(bus.resp_hit_o), 32'd1);
            check_output("hold resp_index", 32'(bus.resp_index_o), 32'd1);
            check_output("hold query_ready", 32'(bus.query_ready_o), 32'd0);
        end
        bus.query_valid_i = 1'b0;
        bus.resp_ready_i  = 1'b1;
        tick();
        bus.resp_ready_i  = 1'b0;
        check_output("release query_ready", 32'(bus.query_ready_o), 32'd1);
        tick();
        check_output("ignored query no resp", 32'(bus.resp_valid_o), 32'd0);
        check_output("ignored query idle", 32'(bus.query_ready_o), 32'd1);

        // Flush with a write on the 3rd scan cycle of an 8-entry scan.
        bus.query_valid_i = 1'b1;
        bus.query_addr_i  = 32'h7000_0000;
        tick();
        bus.query_valid_i = 1'b0;
        tick();
        tick();
        bus.flush_i    = 1'b1;
        bus.wr_valid_i = 1'b1;
        bus.wr_addr_i  = 32'h8000_0200;
        lat = 3;
        tick();
        bus.flush_i    = 1'b0;
        bus.wr_valid_i = 1'b0;
        check_output("flush resp_valid", 32'(bus.resp_valid_o), 32'd1);
        check_output("flush latency", 32'(bus.resp_valid_o ? lat : 0), 32'd3);
        check_output("flush resp_hit", 32'(bus.resp_hit_o), 32'd0);
        check_output("flush resp_index", 32'(bus.resp_index_o), 32'd0);
        check_output("flush count", 32'(bus.count_o), 32'd1);
        bus.resp_ready_i = 1'b1;
        tick();
        bus.resp_ready_i = 1'b0;
        apply_stimulus("post-flush hit", 32'h8000_0200, 1'b1, 3'd0, 2);

        // Asynchronous reset in the middle of a scan.
        for (int i = 0; i < 4; i++) begin
            write_entry(32'hA000_0000 + 32'(4 * i));
        end
        check_output("count before rst", 32'(bus.count_o), 32'd5);
        bus.query_valid_i = 1'b1;
        bus.query_addr_i  = 32'h7000_0000;
        tick();
        bus.query_valid_i = 1'b0;
        tick();
        check_output("mid-scan query_ready", 32'(bus.query_ready_o), 32'd0);
        check_output("mid-scan resp_valid", 32'(bus.resp_valid_o), 32'd0);
        #2;
        rst_i = 1'b1;
        #1;
        check_output("async rst query_ready", 32'(bus.query_ready_o), 32'd1);
        check_output("async rst resp_valid", 32'(bus.resp_valid_o), 32'd0);
        check_output("async rst count", 32'(bus.count_o), 32'd0);
        tick();
        rst_i = 1'b0;
        tick();
        apply_stimulus("after rst empty", 32'hA000_0000, 1'b0, 3'd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stack_store_log_scanner.md
Name: stack_store_log_scanner

Overview:
- Read/lookup end of the stack-store address log that the branch unit fills on sp/fp-based stores.
- Records store addresses in a DEPTH-entry circular log.
- Answers lookup queries with a multi-cycle newest-first scan, using a valid/ready handshake on both the query side and the response side.
- Sits beside the branch unit in the EX stage. The branch unit owns the write side; the crash/flag logic issues queries and consumes the hit/miss result.

Parameters:
- DEPTH, 8, number of log entries; must be a power of 2, minimum 2.
- AW, 32, address width.
- MATCH_LSB, 2, low address bits ignored in comparisons (word granularity, so SB/SH/SW to the same word match).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- wr_valid_i  in  1  log-write strobe, one entry per cycle, never back-pressured.
- wr_addr_i  in  AW  store address to record.
- flush_i  in  1  empty the log and abort any scan.
- query_valid_i  in  1  lookup request.
- query_ready_o  out  1  scanner can accept a query.
- query_addr_i  in  AW  address to look up.
- resp_valid_o  out  1  response available.
- resp_ready_i  in  1  consumer accepts response.
- resp_hit_o  out  1  address found in log.
- resp_index_o  out  $clog2(DEPTH)  physical slot of the match; 0 on a miss.
- count_o  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (asynchronous, active-high): count=0, write pointer=0, FSM=IDLE. Outputs at reset: query_ready_o=1, resp_valid_o=0, resp_hit_o=0, resp_index_o=0, count_o=0. Storage contents are don't-care.
- Write, every cycle, independent of FSM state:
  - If wr_valid_i: mem[wptr] <= wr_addr_i; wptr <= wptr+1 modulo DEPTH.
  - count increments and saturates at DEPTH.
  - When the log is full, the oldest entry is overwritten silently.
- Flush:
  - flush_i sets count=0 and wptr=0.
  - If wr_valid_i is high in the same cycle, the write lands after the flush: mem[0]=wr_addr_i, wptr=1, count=1.
- FSM states IDLE, SCAN, RESP:
  - IDLE: query_ready_o=1. On query_valid_i the block latches query_addr_i, snapshots the start index (wptr-1) and the scan length (count; a simultaneous write is excluded), then goes to SCAN. If the snapshot length is 0, it goes directly to RESP with a miss.
  - SCAN: query_ready_o=0. Each cycle it compares one slot, newest first; the index decrements modulo DEPTH, wrapping 0 to DEPTH-1.
    - Comparison: mem[idx][AW-1:MATCH_LSB] == q[AW-1:MATCH_LSB].
    - Hit: go to RESP with hit=1 and index=idx.
    - Scan length exhausted with no hit: go to RESP with a miss.
    - Writes during SCAN are allowed. The scan compares current slot contents and does not extend to new entries.
    - flush_i during SCAN: go to RESP with a miss.
  - RESP: resp_valid_o=1. resp_hit_o and resp_index_o are held stable until resp_ready_i. On resp_valid_o && resp_ready_i the FSM returns to IDLE.
    - query_ready_o stays 0 in RESP, so a new query is accepted at the earliest one cycle after the response handshake.
    - flush_i in RESP does not alter the pending response.
- Latency, counting cycles after the query-accept edge:
  - Hit at the k-th newest entry: resp_valid_o is asserted k+1 cycles later.
  - Miss with n entries scanned: n+1 cycles.
  - Empty log: 1 cycle.
- Reset asserted mid-scan or mid-response: the FSM returns to IDLE immediately and the pending response is dropped.

Test Plan:
- Reset, then query 0x8000_0010 -> query_ready_o=1 before the query; resp_valid_o one cycle after acceptance with hit=0 and index=0; count_o=0.
- Write 0x8000_0100, 0x8000_0104, 0x8000_0108 (slots 0-2), then query 0x8000_0105 -> hit=1, index=1; resp_valid_o asserted 3 cycles after acceptance (second-newest entry, low 2 bits ignored).
- Write DEPTH+2 = 10 addresses A0..A9 -> count_o saturates at 8, wptr=2. Query A0 -> miss after 9 cycles. Query A9 -> hit, index=1, latency 2. Query A2 -> hit, index=2.
- Hold resp_ready_i=0 for 5 cycles in RESP -> resp_valid_o, resp_hit_o and resp_index_o stay stable; query_ready_o=0; a query_valid_i pulse is ignored. Release resp_ready_i -> IDLE and query_ready_o=1 the next cycle.
- Start a scan over 8 entries, assert flush_i on the 3rd SCAN cycle together with wr_valid_i=0x8000_0200 -> response is a miss; count_o=1; a subsequent query for 0x8000_0200 hits at index 0.
- Assert rst_i asynchronously mid-SCAN (between clock edges) -> resp_valid_o=0, query_ready_o=1 and count_o=0 immediately, without waiting for a clock edge.
